// File: rtl/cache_ctrl.sv
// cache_ctrl: two-line fully associative write-back, write-allocate cache
// controller for a 7-word (addr 0..6) memory. One request at a time; req_i is
// only looked at in IDLE. All outputs are registered.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i   CPU request (addr 7 is illegal -> err_o)
//   rdata_o/done_o/err_o/busy_o CPU response; done_o is a one-cycle pulse
//   mem_tag_o/mem_wb_o/mem_wdata_o  memory select / write-back strobe / data
//   mem_rdata_i/mem_ok_i   memory read data and its valid confirm
module cache_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [2:0] addr_i,
  input  logic [3:0] wdata_i,
  output logic [3:0] rdata_o,
  output logic       done_o,
  output logic       err_o,
  output logic       busy_o,
  output logic [2:0] mem_tag_o,
  output logic       mem_wb_o,
  output logic [3:0] mem_wdata_o,
  input  logic [3:0] mem_rdata_i,
  input  logic       mem_ok_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WB    = 3'd2,
    FILL  = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [2:0] TAG_IDLE = 3'b111;

  state_t          state_q;
  logic [1:0]      vld_q;
  logic [1:0]      dty_q;
  logic [1:0][2:0] tag_q;
  logic [1:0][3:0] dat_q;
  logic            lru_q;     // index of the line to evict on the next miss

  logic            we_q;
  logic [2:0]      addr_q;
  logic [3:0]      wdata_q;

  logic [3:0]      rdata_q;
  logic            done_q;
  logic            err_q;
  logic            busy_q;
  logic [2:0]      mem_tag_q;
  logic            mem_wb_q;
  logic [3:0]      mem_wdata_q;

  // A line is only filled after missing in both, so at most one line can hit.
  logic hit0, hit1, hit, hit_idx;
  always_comb begin
    hit0    = vld_q[0] && (tag_q[0] == addr_q);
    hit1    = vld_q[1] && (tag_q[1] == addr_q);
    hit     = hit0 || hit1;
    hit_idx = hit1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      vld_q       <= '0;
      dty_q       <= '0;
      tag_q       <= '0;
      dat_q       <= '0;
      lru_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_tag_q   <= TAG_IDLE;
      mem_wb_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            busy_q <= 1'b1;
            if (addr_i == 3'd7) begin
              // Illegal address: answer straight away, cache untouched.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= RESP;
            end else begin
              we_q    <= we_i;
              addr_q  <= addr_i;
              wdata_q <= wdata_i;
              state_q <= CHECK;
            end
          end
        end

        CHECK: begin
          if (hit) begin
            if (we_q) begin
              dat_q[hit_idx] <= wdata_q;
              dty_q[hit_idx] <= 1'b1;
            end else begin
              rdata_q <= dat_q[hit_idx];
            end
            lru_q   <= ~hit_idx;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= RESP;
          end else if (vld_q[lru_q] && dty_q[lru_q]) begin
            // Dirty victim: present it to memory during the WB cycle.
            mem_wb_q    <= 1'b1;
            mem_tag_q   <= tag_q[lru_q];
            mem_wdata_q <= dat_q[lru_q];
            state_q     <= WB;
          end else begin
            mem_tag_q <= addr_q;
            state_q   <= FILL;
          end
        end

        WB: begin
          dty_q[lru_q] <= 1'b0;
          mem_wb_q     <= 1'b0;
          mem_tag_q    <= addr_q;
          state_q      <= FILL;
        end

        FILL: begin
          state_q <= WAIT;
        end

        WAIT: begin
          if (mem_ok_i) begin
            vld_q[lru_q] <= 1'b1;
            dty_q[lru_q] <= 1'b0;
            tag_q[lru_q] <= addr_q;
            dat_q[lru_q] <= mem_rdata_i;
            mem_tag_q    <= TAG_IDLE;
            // Re-check now hits the fresh line and applies a pending write.
            state_q      <= CHECK;
          end
        end

        RESP: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q   <= IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          mem_wb_q  <= 1'b0;
          mem_tag_q <= TAG_IDLE;
        end
      endcase
    end
  end

  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign mem_tag_o   = mem_tag_q;
  assign mem_wb_o    = mem_wb_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed table-driven bench for cache_ctrl, plus hand-written
// sequences for reset during WAIT and req held high across transactions.
// Latency k = index of the cycle (1 = first cycle after the accept edge) in
// which done is observed high at the falling edge.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [3:0] wdata = 4'd0;
  logic [3:0] rdata;
  logic       done;
  logic       err;
  logic       busy;
  logic [2:0] mem_tag;
  logic       mem_wb;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       mem_ok = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .mem_tag_o   (mem_tag),
    .mem_wb_o    (mem_wb),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ok_i    (mem_ok)
  );

  // Backing memory: fixed initial contents, updated by write-backs.
  logic [3:0] mem [0:7] = '{4'hA, 4'h1, 4'h7, 4'h2, 4'h4, 4'h9, 4'hC, 4'h0};
  assign mem_rdata = mem[mem_tag];
  always @(posedge clk) begin
    if (mem_wb) mem[mem_tag] <= mem_wdata;
  end

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [3:0] wdata;
    int         lat;
    logic [3:0] rdata;
    logic       err;
    logic       wb;
    logic [2:0] wb_tag;
    logic [3:0] wb_data;
    logic       traffic;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic w, input logic [2:0] a, input logic [3:0] d,
                              input int l, input logic [3:0] rd, input logic e,
                              input logic b, input logic [2:0] bt, input logic [3:0] bd,
                              input logic t);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.lat = l; v.rdata = rd; v.err = e;
    v.wb = b; v.wb_tag = bt; v.wb_data = bd; v.traffic = t;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   lat_obs;
    int   wb_cnt;
    logic [2:0] wb_tag_obs;
    logic [3:0] wb_dat_obs;
    logic bad_tag;
    logic traffic_obs;
    string nm;
    v = vecs[idx];
    nm = $sformatf("v%0d", idx);
    lat_obs = 0; wb_cnt = 0; wb_tag_obs = 3'd0; wb_dat_obs = 4'd0;
    bad_tag = 1'b0; traffic_obs = 1'b0;
    @(negedge clk);
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (mem_tag != 3'b111) traffic_obs = 1'b1;
      if (mem_wb) begin
        wb_cnt++;
        wb_tag_obs = mem_tag;
        wb_dat_obs = mem_wdata;
      end else if (mem_tag != 3'b111 && mem_tag != v.addr) begin
        bad_tag = 1'b1;
      end
      if (done) begin
        lat_obs = k;
        break;
      end
    end
    chk({nm, "_latency"}, lat_obs, v.lat);
    chk({nm, "_rdata"}, rdata, v.rdata);
    chk({nm, "_err"}, err, v.err);
    chk({nm, "_traffic"}, traffic_obs, v.traffic);
    chk({nm, "_fill_tag_ok"}, bad_tag, 1'b0);
    chk({nm, "_wb_cycles"}, wb_cnt, v.wb ? 1 : 0);
    if (v.wb) begin
      chk({nm, "_wb_tag"}, wb_tag_obs, v.wb_tag);
      chk({nm, "_wb_data"}, wb_dat_obs, v.wb_data);
    end
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 1'b0);
    chk({nm, "_idle_busy"}, busy, 1'b0);
    chk({nm, "_idle_tag"}, mem_tag, 3'b111);
    if (v.wb) chk({nm, "_wdata_hold"}, mem_wdata, v.wb_data);
  endtask

  initial begin
    logic [15:0] done_mask;
    logic [15:0] idle_mask;

    //             we    addr  wdata lat rdata err  wb    wbtag wbdat traffic
    vecs[0]  = mk(1'b0, 3'd0, 4'h0, 5, 4'hA, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1); // cold miss
    vecs[1]  = mk(1'b0, 3'd0, 4'h0, 2, 4'hA, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0); // read hit
    vecs[2]  = mk(1'b1, 3'd0, 4'h5, 2, 4'hA, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0); // write hit
    vecs[3]  = mk(1'b0, 3'd3, 4'h0, 5, 4'h2, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1); // clean miss
    vecs[4]  = mk(1'b0, 3'd4, 4'h0, 6, 4'h4, 1'b0, 1'b1, 3'd0, 4'h5, 1'b1); // dirty miss
    vecs[5]  = mk(1'b0, 3'd7, 4'h0, 1, 4'h4, 1'b1, 1'b0, 3'd0, 4'h0, 1'b0); // illegal
    vecs[6]  = mk(1'b0, 3'd0, 4'h0, 5, 4'h5, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1); // refetch wb data
    vecs[7]  = mk(1'b1, 3'd4, 4'hE, 2, 4'h5, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0); // write hit
    vecs[8]  = mk(1'b1, 3'd6, 4'h3, 5, 4'h5, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1); // write miss
    vecs[9]  = mk(1'b0, 3'd2, 4'h0, 6, 4'h7, 1'b0, 1'b1, 3'd4, 4'hE, 1'b1); // dirty miss
    vecs[10] = mk(1'b0, 3'd6, 4'h0, 2, 4'h3, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0); // allocated write
    vecs[11] = mk(1'b0, 3'd4, 4'h0, 5, 4'hE, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1); // refetch wb data
    vecs[12] = mk(1'b0, 3'd1, 4'h0, 6, 4'h1, 1'b0, 1'b1, 3'd6, 4'h3, 1'b1); // dirty miss
    vecs[13] = mk(1'b0, 3'd0, 4'h0, 5, 4'h5, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1); // miss after reset

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 4'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_tag", mem_tag, 3'b111);
    chk("rst_mem_wb", mem_wb, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 4'h0);
    rst = 1'b0;

    for (int i = 0; i <= 12; i++) run_vec(i);

    // Reset asserted while waiting on memory
    @(negedge clk);
    mem_ok = 1'b0; req = 1'b1; we = 1'b0; addr = 3'd5;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", busy, 1'b1);
    chk("wait_mem_tag", mem_tag, 3'd5);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_mem_tag", mem_tag, 3'b111);
    chk("arst_done", done, 1'b0);
    chk("arst_rdata", rdata, 4'h0);
    @(negedge clk);
    rst = 1'b0; mem_ok = 1'b1;
    run_vec(13);

    // req held high: clean miss on addr 5, then a re-accepted hit
    done_mask = '0;
    idle_mask = '0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 3'd5;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) done_mask[k] = 1'b1;
      if (!busy && k <= 8) idle_mask[k] = 1'b1;
      if (k == 8) req = 1'b0;
    end
    chk("held_done_cycles", done_mask, 16'h0120);
    chk("held_idle_cycles", idle_mask, 16'h0040);
    chk("held_rdata", rdata, 4'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
